stream_arbiter: RTL



---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 29 ++
 rtl/stream_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the stream arbiters.
// Holds the FSM encoding and the round-robin pointer increment.
package arb_pkg;

    localparam int ARB_MAX_N = 16;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after ptr_i, wrapping.
// Purely combinational; reusable by any arbiter that keeps its own pointer.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0] rot;
    int           off;
    int           sum;

    always_comb begin
        // rotate so ptr_i lands on bit 0, encode, then rotate back
        rot     = N'({req_i, req_i} >> ptr_i);
        found_o = |req_i;
        off     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        sum   = int'(ptr_i) + off;
        idx_o = IDX_W'((sum >= N) ? sum - N : sum);
    end

endmodule

// File: rtl/stream_arbiter.sv
// N-to-1 ready/valid merge, round-robin per packet, registered output.
// The source index travels with each beat so responses can be routed back.
module stream_arbiter
    import arb_pkg::*;
#(
    parameter type   T    = logic [31:0],
    parameter int    N    = 2,
    parameter string NAME = "arb",
    localparam int   DW   = $bits(T),
    localparam int   IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     up_valid,
    output logic [N-1:0]     up_ready,
    input  logic [N*DW-1:0]  up_data,
    input  logic [N-1:0]     up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [DW-1:0]    down_data,
    output logic             down_last,
    output logic [IDX_W-1:0] down_source
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] lock_q;
    logic             dv_q, dv_d;
    logic [DW-1:0]    dd_q, dd_d;
    logic             dl_q, dl_d;
    logic [IDX_W-1:0] ds_q, ds_d;

    logic             found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] grant;
    logic             granted;
    logic             load;
    logic             xfer;
    logic [DW-1:0]    beat_data;
    logic             beat_last;

    rr_picker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (up_valid),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    assign load      = !dv_q || down_ready;
    assign granted   = (state_q == LOCKED) || found;
    assign grant     = (state_q == LOCKED) ? lock_q : pick_idx;
    assign beat_data = up_data[int'(grant)*DW +: DW];
    assign beat_last = up_last[grant];
    assign xfer      = |(up_valid & up_ready);

    // ready is withheld while reset is low so nothing is handed over
    always_comb begin
        up_ready = '0;
        if (reset && load && granted) up_ready[grant] = 1'b1;
    end

    always_comb begin
        dv_d = dv_q;
        dd_d = dd_q;
        dl_d = dl_q;
        ds_d = ds_q;
        if (load) begin
            dv_d = xfer;
            if (xfer) begin
                dd_d = beat_data;
                dl_d = beat_last;
                ds_d = grant;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            dv_q    <= 1'b0;
            dd_q    <= '0;
            dl_q    <= 1'b0;
            ds_q    <= '0;
        end else begin
            dv_q <= dv_d;
            dd_q <= dd_d;
            dl_q <= dl_d;
            ds_q <= ds_d;
            if (xfer) begin
                unique case (state_q)
                    IDLE: begin
                        if (beat_last) begin
                            ptr_q <= IDX_W'(rr_next(int'(grant), N));
                        end else begin
                            state_q <= LOCKED;
                            lock_q  <= grant;
                        end
                    end
                    LOCKED: begin
                        if (beat_last) begin
                            state_q <= IDLE;
                            ptr_q   <= IDX_W'(rr_next(int'(lock_q), N));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign down_valid  = dv_q;
    assign down_data   = dd_q;
    assign down_last   = dl_q;
    assign down_source = ds_q;

`ifndef SYNTHESIS
`define LOG(tag, what, idx) $info("[%s] %s %0d", tag, what, idx)
    always_ff @(posedge clock) begin
        if (reset && xfer && state_q == IDLE) `LOG(NAME, "grant", grant);
        if (reset && xfer && beat_last) `LOG(NAME, "end", grant);
    end
`undef LOG
`endif

endmodule
